// File: rtl/lfsr_checker.sv
// Receive-side checker for the 80-bit serial LFSR keystream.
// Self-syncs on the stream, then free-runs to count bit errors.
module lfsr_checker #(
  parameter int             W        = 80,
  parameter logic [W-1:0]   TAPS     = 80'h0000_0000_0060_0000_0003,
  parameter int             LOCK_CNT = 16,
  parameter int             LOSS_CNT = 8,
  parameter int             CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Ser_in,
  input  logic             in_valid,
  input  logic             clr_err,
  output logic [W-1:0]     Par_out,
  output logic             locked,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count
);

  localparam int FW = $clog2(W + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  localparam logic [1:0] S_FILL   = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     win_q, win_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    miss_q, miss_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic exp_bit;
  logic miss;

  // Next stream bit as the generator would produce it from the window.
  assign exp_bit = ^(win_q & TAPS);
  assign miss    = Ser_in ^ exp_bit;

  // Sync/lock state machine and error statistics.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    flag_d  = 1'b0;
    cnt_d   = cnt_q;
    if (in_valid) begin
      unique case (1'b1)
        state_q == S_FILL: begin
          win_d  = {Ser_in, win_q[W-1:1]};
          fill_d = fill_q + 1'b1;
          if (fill_q == FW'(W - 1)) begin
            state_d = S_VERIFY;
            fill_d  = '0;
            match_d = '0;
          end
        end
        state_q == S_VERIFY: begin
          win_d = {Ser_in, win_q[W-1:1]};
          if (!miss) begin
            match_d = match_q + 1'b1;
            if (match_q == MW'(LOCK_CNT - 1)) begin
              state_d = S_LOCKED;
              miss_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        state_q == S_LOCKED: begin
          // Free-run on the prediction so a bad bit cannot corrupt the window.
          win_d = {exp_bit, win_q[W-1:1]};
          if (miss) begin
            flag_d = 1'b1;
            miss_d = miss_q + 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (miss_q == LW'(LOSS_CNT - 1)) begin
              state_d = S_FILL;
              fill_d  = '0;
              miss_d  = '0;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = S_FILL;
      endcase
    end
    if (clr_err) cnt_d = '0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
      win_q   <= '0;
      fill_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Par_out   = win_q;
  assign locked    = (state_q == S_LOCKED);
  assign err_flag  = flag_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed stream scenarios,
// per-cycle model compare and literal checkpoints.
module tb_lfsr_checker;

  localparam logic [79:0] TAPS = 80'h0000_0000_0060_0000_0003;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Ser_in = 1'b0;
  logic        in_valid = 1'b0;
  logic        clr_err = 1'b0;
  logic [79:0] Par_out, Par_out_s;
  logic        locked, locked_s;
  logic        err_flag, err_flag_s;
  logic [15:0] err_count;
  logic [3:0]  err_count_s;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [79:0] gst;

  lfsr_checker u_dut (
    .clk(clk), .rst(rst), .Ser_in(Ser_in),
    .in_valid(in_valid), .clr_err(clr_err),
    .Par_out(Par_out), .locked(locked),
    .err_flag(err_flag), .err_count(err_count)
  );

  lfsr_checker #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .Ser_in(Ser_in),
    .in_valid(in_valid), .clr_err(clr_err),
    .Par_out(Par_out_s), .locked(locked_s),
    .err_flag(err_flag_s), .err_count(err_count_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [79:0] a,
                       input logic [79:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          hist[$];
  int          m_mode;
  int          m_fill, m_match, m_miss;
  int          m_err16, m_err4;
  bit          m_flag;
  logic [79:0] m_par;

  always @(posedge clk) begin
    bit pred;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < 80; i++) hist.push_back(1'b0);
      m_mode = 0; m_fill = 0; m_match = 0; m_miss = 0;
      m_err16 = 0; m_err4 = 0; m_flag = 0;
    end else begin
      m_flag = 0;
      if (in_valid) begin
        pred = 0;
        for (int i = 0; i < 80; i++)
          if (TAPS[i]) pred ^= hist[i];
        if (m_mode == 0) begin
          hist.push_back(Ser_in); void'(hist.pop_front());
          m_fill++;
          if (m_fill == 80) begin
            m_mode = 1; m_fill = 0; m_match = 0;
          end
        end else if (m_mode == 1) begin
          hist.push_back(Ser_in); void'(hist.pop_front());
          if (Ser_in == pred) begin
            m_match++;
            if (m_match == 16) begin
              m_mode = 2; m_miss = 0;
            end
          end else m_match = 0;
        end else begin
          hist.push_back(pred); void'(hist.pop_front());
          if (Ser_in != pred) begin
            m_flag = 1;
            m_err16 = (m_err16 < 65535) ? m_err16 + 1 : 65535;
            m_err4  = (m_err4 < 15) ? m_err4 + 1 : 15;
            m_miss++;
            if (m_miss == 8) begin
              m_mode = 0; m_fill = 0; m_miss = 0;
            end
          end else m_miss = 0;
        end
      end
      if (clr_err) begin
        m_err16 = 0; m_err4 = 0;
      end
    end
    for (int i = 0; i < 80; i++) m_par[i] = hist[i];
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("par", Par_out, m_par);
      check("par_s", Par_out_s, m_par);
      check("locked", 80'(locked), 80'(m_mode == 2));
      check("locked_s", 80'(locked_s), 80'(m_mode == 2));
      check("err_flag", 80'(err_flag), 80'(m_flag));
      check("err_flag_s", 80'(err_flag_s), 80'(m_flag));
      check("err_cnt", 80'(err_count), 80'(m_err16));
      check("err_cnt_s", 80'(err_count_s), 80'(m_err4));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic bit gen_next();
    bit b;
    b = gst[0];
    gst = {^(gst & TAPS), gst[79:1]};
    return b;
  endfunction

  task automatic send(input bit b, input bit v, input bit c);
    Ser_in = b; in_valid = v; clr_err = c;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b0; clr_err = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic wait_lock(input string nm, input bit gaps);
    int nv;
    bit done;
    bit v;
    nv = 0; done = 0;
    for (int k = 0; k < 600 && !done; k++) begin
      v = gaps ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
      if (v) begin
        send(gen_next(), 1'b1, 1'b0);
        nv++;
      end else begin
        send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      if (locked) done = 1;
    end
    check(nm, 80'(nv), 80'd96);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    gst = 80'h123456789ABCDEF01234;
    @(posedge clk); #1;
    chk_en = 1'b1;
    do_reset(2);
    check("rst_locked", 80'(locked), 80'd0);
    check("rst_flag", 80'(err_flag), 80'd0);
    check("rst_cnt", 80'(err_count), 80'd0);
    check("rst_par", Par_out, 80'd0);

    // Clean lock, then a long clean run.
    wait_lock("lock_bits", 1'b0);
    repeat (200) send(gen_next(), 1'b1, 1'b0);
    check("clean_cnt", 80'(err_count), 80'd0);

    // Single flipped bit.
    send(~gen_next(), 1'b1, 1'b0);
    check("single_flag", 80'(err_flag), 80'd1);
    check("single_cnt", 80'(err_count), 80'd1);
    check("single_lock", 80'(locked), 80'd1);
    send(gen_next(), 1'b1, 1'b0);
    check("single_flag_off", 80'(err_flag), 80'd0);
    repeat (20) send(gen_next(), 1'b1, 1'b0);
    check("single_cnt_hold", 80'(err_count), 80'd1);

    // Clear alone, then clear coinciding with a mismatch.
    send(gen_next(), 1'b1, 1'b1);
    check("clr_cnt", 80'(err_count), 80'd0);
    send(~gen_next(), 1'b1, 1'b1);
    check("clr_win_cnt", 80'(err_count), 80'd0);
    check("clr_win_flag", 80'(err_flag), 80'd1);
    send(gen_next(), 1'b1, 1'b0);

    // Loss of lock after 8 consecutive misses, then relock.
    repeat (7) send(~gen_next(), 1'b1, 1'b0);
    check("loss_hold", 80'(locked), 80'd1);
    send(~gen_next(), 1'b1, 1'b0);
    check("loss_lock", 80'(locked), 80'd0);
    check("loss_cnt", 80'(err_count), 80'd8);
    wait_lock("relock_bits", 1'b0);
    check("relock_cnt", 80'(err_count), 80'd8);

    // Saturation on the 4-bit instance.
    send(gen_next(), 1'b1, 1'b1);
    repeat (20) begin
      send(~gen_next(), 1'b1, 1'b0);
      repeat (3) send(gen_next(), 1'b1, 1'b0);
    end
    check("sat_cnt16", 80'(err_count), 80'd20);
    check("sat_cnt4", 80'(err_count_s), 80'd15);
    check("sat_lock", 80'(locked), 80'd1);

    // Gapped valid pattern 1,0,0,1.
    do_reset(2);
    wait_lock("gap_bits", 1'b1);
    repeat (40) send(gen_next(), 1'b1, 1'b0);
    check("gap_cnt", 80'(err_count), 80'd0);

    // Reset while in VERIFY.
    do_reset(1);
    repeat (85) send(gen_next(), 1'b1, 1'b0);
    check("verify_unlocked", 80'(locked), 80'd0);
    do_reset(1);
    check("midrst_par", Par_out, 80'd0);
    wait_lock("midrst_bits", 1'b0);

    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
